// File: rtl/jtframe_dwnld_pkg.sv
// Shared types and constants for the ROM download path.
package jtframe_dwnld_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SDRAM,
      ST_PROM,
      ST_GAP
   } state_t;

   localparam logic [1:0] MASK_LO   = 2'b10;
   localparam logic [1:0] MASK_HI   = 2'b01;
   localparam logic [1:0] MASK_NONE = 2'b11;

   // Active-low byte-lane enable selected by the byte address LSB
   function automatic logic [1:0] lane_mask(input logic a0);
      return a0 ? MASK_HI : MASK_LO;
   endfunction

endpackage

// File: rtl/jtframe_sync_fifo.sv
// Generic synchronous FIFO, combinational head read, one-cycle push-to-visible.
// Push is ignored when full and pop is ignored when empty.
module jtframe_sync_fifo #(
   parameter int W     = 30,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic [W-1:0] i_din,
   input  logic         i_pop,
   output logic [W-1:0] o_dout,
   output logic         o_full,
   output logic         o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  r_wr_ptr;
   logic [AW:0]  r_rd_ptr;
   logic [W-1:0] r_mem [DEPTH];

   // Extra MSB on each pointer distinguishes full from empty
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_push && !o_full)
            r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (i_pop && !o_empty)
            r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (i_push && !o_full)
         r_mem[r_wr_ptr[AW-1:0]] <= i_din;
   end

endmodule

// File: rtl/jtframe_prog_fifo.sv
// Buffers HPS loader bytes and issues SDRAM writes (held until prog_rdy) or PROM pulses.
// First write request two cycles after the byte; bytes arriving while full are dropped and flagged.
module jtframe_prog_fifo
   import jtframe_dwnld_pkg::*;
#(
   parameter int          DEPTH      = 4,
   parameter logic [21:0] PROM_START = 22'h3F_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        downloading,
   input  logic [21:0] ioctl_addr,
   input  logic [7:0]  ioctl_data,
   input  logic        ioctl_wr,
   output logic [21:0] prog_addr,
   output logic [7:0]  prog_data,
   output logic [1:0]  prog_mask,
   output logic        prog_we,
   input  logic        prog_rdy,
   output logic        prom_we,
   output logic [15:0] prom_addr,
   output logic [7:0]  prom_data,
   output logic        dwnld_done,
   output logic        overflow
);
   logic        w_full;
   logic        w_empty;
   logic        w_push;
   logic        w_pop;
   logic [29:0] w_head;
   logic [21:0] w_head_addr;
   logic [7:0]  w_head_data;
   logic        w_dl_rise;
   logic        w_dl_fall;
   state_t      r_state;
   state_t      w_next;
   logic        r_dl;
   logic        r_pending;

   assign w_push    = ioctl_wr && downloading && !w_full;
   assign w_dl_rise = downloading && !r_dl;
   assign w_dl_fall = !downloading && r_dl;
   assign {w_head_addr, w_head_data} = w_head;

   jtframe_sync_fifo #(.W(30), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_din   ({ioctl_addr, ioctl_data}),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_comb begin
      w_next = r_state;
      w_pop  = 1'b0;
      case (r_state)
         ST_IDLE:
            if (!w_empty)
               w_next = (w_head_addr < PROM_START) ? ST_SDRAM : ST_PROM;
         ST_SDRAM:
            if (prog_rdy) begin
               w_pop  = 1'b1;
               w_next = ST_GAP;
            end
         ST_PROM: begin
            w_pop  = 1'b1;
            w_next = ST_GAP;
         end
         default:
            w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   assign prog_we = (r_state == ST_SDRAM);
   assign prom_we = (r_state == ST_PROM);

   // Head is captured on leaving IDLE so outputs stay stable through the handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prog_addr <= '0;
         prog_data <= '0;
         prog_mask <= MASK_NONE;
         prom_addr <= '0;
         prom_data <= '0;
      end else if (r_state == ST_IDLE) begin
         if (w_next == ST_SDRAM) begin
            prog_addr <= {1'b0, w_head_addr[21:1]};
            prog_data <= w_head_data;
            prog_mask <= lane_mask(w_head_addr[0]);
         end
         if (w_next == ST_PROM) begin
            prom_addr <= w_head_addr[15:0] - PROM_START[15:0];
            prom_data <= w_head_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dl       <= 1'b0;
         r_pending  <= 1'b0;
         dwnld_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         r_dl       <= downloading;
         dwnld_done <= 1'b0;
         if (w_dl_rise)
            r_pending <= 1'b0;
         else if (w_dl_fall)
            r_pending <= 1'b1;
         else if (r_pending && r_state == ST_IDLE && w_empty) begin
            r_pending  <= 1'b0;
            dwnld_done <= 1'b1;
         end
         if (w_dl_rise)
            overflow <= 1'b0;
         if (ioctl_wr && downloading && w_full)
            overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_jtframe_prog_fifo.sv
// Directed scoreboard bench for jtframe_prog_fifo.
module tb_jtframe_prog_fifo;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        downloading = 1'b0;
   logic [21:0] ioctl_addr = '0;
   logic [7:0]  ioctl_data = '0;
   logic        ioctl_wr = 1'b0;
   logic        prog_rdy = 1'b0;
   logic [21:0] prog_addr;
   logic [7:0]  prog_data;
   logic [1:0]  prog_mask;
   logic        prog_we;
   logic        prom_we;
   logic [15:0] prom_addr;
   logic [7:0]  prom_data;
   logic        dwnld_done;
   logic        overflow;

   jtframe_prog_fifo dut (
      .clk(clk), .rst(rst), .downloading(downloading),
      .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
      .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
      .prog_we(prog_we), .prog_rdy(prog_rdy),
      .prom_we(prom_we), .prom_addr(prom_addr), .prom_data(prom_data),
      .dwnld_done(dwnld_done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0, n_fail = 0;
   int cyc = 0, n_wr = 0, n_prom = 0, n_done = 0;
   int done_cyc = -1, last_ack = -1;
   logic [31:0] sd_q[$];
   logic [23:0] pr_q[$];
   logic [31:0] e_sd;
   logic [23:0] e_pr;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (prog_we && prog_rdy) begin
            n_wr++;
            last_ack = cyc;
            chk("sd_write_expected", 32'(sd_q.size() != 0), 32'd1);
            if (sd_q.size() != 0) begin
               e_sd = sd_q.pop_front();
               chk("sd_write", {prog_addr, prog_data, prog_mask}, e_sd);
            end
         end
         if (prom_we) begin
            n_prom++;
            chk("prom_write_expected", 32'(pr_q.size() != 0), 32'd1);
            if (pr_q.size() != 0) begin
               e_pr = pr_q.pop_front();
               chk("prom_write", {8'h0, prom_addr, prom_data}, {8'h0, e_pr});
            end
         end
         if (dwnld_done) begin
            n_done++;
            done_cyc = cyc;
         end
      end
   end

   task automatic step(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(logic [21:0] a, logic [7:0] d, bit accept);
      ioctl_addr = a;
      ioctl_data = d;
      ioctl_wr   = 1'b1;
      if (accept) begin
         if (a < 22'h3F0000)
            sd_q.push_back({1'b0, a[21:1], d, (a[0] ? 2'b01 : 2'b10)});
         else
            pr_q.push_back({16'(a - 22'h3F0000), d});
      end
      step();
      ioctl_wr = 1'b0;
   endtask

   task automatic wait_drain(string tag);
      for (int i = 0; i < 200 && (sd_q.size() != 0 || pr_q.size() != 0); i++)
         step();
      step(3);
      chk(tag, 32'(sd_q.size() + pr_q.size()), 32'd0);
   endtask

   initial begin
      int w0, hi, sw, fall_cyc;
      #1 rst = 1'b1;
      step(2);
      chk("rst_prog_we", 32'(prog_we), 32'd0);
      chk("rst_prom_we", 32'(prom_we), 32'd0);
      chk("rst_done", 32'(dwnld_done), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_prog_addr", 32'(prog_addr), 32'd0);
      chk("rst_prog_data", 32'(prog_data), 32'd0);
      chk("rst_prog_mask", 32'(prog_mask), 32'd3);
      chk("rst_prom_addr", 32'(prom_addr), 32'd0);
      chk("rst_prom_data", 32'(prom_data), 32'd0);
      rst = 1'b0;
      step();
      downloading = 1'b1;
      prog_rdy = 1'b1;
      step();

      // single byte, latency N+2
      send(22'h000005, 8'hA5, 1'b1);
      chk("lat_n1_we", 32'(prog_we), 32'd0);
      step();
      chk("lat_n2_we", 32'(prog_we), 32'd1);
      chk("lat_n2_addr", 32'(prog_addr), 32'h2);
      chk("lat_n2_mask", 32'(prog_mask), 32'h1);
      chk("lat_n2_data", 32'(prog_data), 32'hA5);
      step();
      chk("lat_n3_we", 32'(prog_we), 32'd0);
      wait_drain("single_drain");

      // back-pressure
      prog_rdy = 1'b0;
      for (int i = 0; i < 4; i++) send(22'(i), 8'(8'h10 + i), 1'b1);
      step(20);
      chk("bp_hold_we", 32'(prog_we), 32'd1);
      chk("bp_hold_addr", 32'(prog_addr), 32'd0);
      w0 = n_wr;
      prog_rdy = 1'b1;
      wait_drain("bp_drain");
      chk("bp_writes", 32'(n_wr - w0), 32'd4);
      chk("bp_overflow", 32'(overflow), 32'd0);

      // overflow
      prog_rdy = 1'b0;
      for (int i = 0; i < 5; i++) send(22'(22'h100 + i), 8'(8'h40 + i), i < 4);
      step();
      chk("ovf_set", 32'(overflow), 32'd1);
      w0 = n_wr;
      prog_rdy = 1'b1;
      wait_drain("ovf_drain");
      step(5);
      chk("ovf_writes", 32'(n_wr - w0), 32'd4);
      downloading = 1'b0;
      step(4);
      chk("ovf_sticky", 32'(overflow), 32'd1);
      downloading = 1'b1;
      step();
      chk("ovf_clear", 32'(overflow), 32'd0);

      // PROM routing
      w0 = n_prom;
      hi = 0;
      sw = 0;
      send(22'h3F0010, 8'h3C, 1'b1);
      for (int i = 0; i < 6; i++) begin
         if (prom_we) hi++;
         if (prog_we) sw++;
         step();
      end
      chk("prom_pulse_len", 32'(hi), 32'd1);
      chk("prom_no_sdram", 32'(sw), 32'd0);
      chk("prom_count", 32'(n_prom - w0), 32'd1);

      // done detection with toggling acknowledge
      prog_rdy = 1'b0;
      n_done = 0;
      for (int i = 0; i < 3; i++) send(22'(22'h200 + i), 8'(8'h60 + i), 1'b1);
      downloading = 1'b0;
      fall_cyc = cyc;
      for (int i = 0; i < 60; i++) begin
         prog_rdy = ~prog_rdy;
         step();
      end
      chk("done_drained", 32'(sd_q.size()), 32'd0);
      chk("done_pulses", 32'(n_done), 32'd1);
      chk("done_after_gap", 32'(done_cyc - last_ack >= 2), 32'd1);
      chk("done_after_fall", 32'(done_cyc - fall_cyc >= 2), 32'd1);

      // reset mid-handshake
      downloading = 1'b1;
      prog_rdy = 1'b0;
      step();
      send(22'h000300, 8'h77, 1'b1);
      for (int i = 0; i < 10 && !prog_we; i++) step();
      chk("rstmid_pre_we", 32'(prog_we), 32'd1);
      rst = 1'b1;
      #1;
      chk("rstmid_we", 32'(prog_we), 32'd0);
      chk("rstmid_prom_we", 32'(prom_we), 32'd0);
      chk("rstmid_mask", 32'(prog_mask), 32'd3);
      chk("rstmid_addr", 32'(prog_addr), 32'd0);
      chk("rstmid_data", 32'(prog_data), 32'd0);
      sd_q.delete();
      step(2);
      rst = 1'b0;
      prog_rdy = 1'b1;
      w0 = n_wr;
      sw = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (prog_we) sw++;
      end
      chk("rstmid_no_write", 32'(sw), 32'd0);
      chk("rstmid_no_ack", 32'(n_wr - w0), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
